// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I datapath. It walks each instruction
// through fetch, decode and execute states, drives the datapath mux and ALU codes,
// and counts retired instructions.
module multicycle_controller (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr,
   input  logic        Zero,
   output logic        PCWrite,
   output logic        AdrSrc,
   output logic        IRWrite,
   output logic        RegWrite,
   output logic        ImmIn,
   output logic        RegSrc,
   output logic        MemWrite,
   output logic [1:0]  ResultSrc,
   output logic [1:0]  ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  MemSize,
   output logic [3:0]  ALUControl,
   output logic [3:0]  ImmSrc,
   output logic [3:0]  State,
   output logic        Illegal,
   output logic [31:0] InstrRetired
);

   localparam logic [3:0] FETCH    = 4'd0;
   localparam logic [3:0] DECODE   = 4'd1;
   localparam logic [3:0] MEMADR   = 4'd2;
   localparam logic [3:0] MEMREAD  = 4'd3;
   localparam logic [3:0] MEMWB    = 4'd4;
   localparam logic [3:0] MEMWRITE = 4'd5;
   localparam logic [3:0] EXECR    = 4'd6;
   localparam logic [3:0] EXECI    = 4'd7;
   localparam logic [3:0] ALUWB    = 4'd8;
   localparam logic [3:0] BRANCH   = 4'd9;
   localparam logic [3:0] JAL      = 4'd10;
   localparam logic [3:0] JALR     = 4'd11;
   localparam logic [3:0] LUI      = 4'd12;
   localparam logic [3:0] AUIPC    = 4'd13;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;
   localparam logic [3:0] ALU_SLTU = 4'b0110;
   localparam logic [3:0] ALU_SLL  = 4'b0111;
   localparam logic [3:0] ALU_SRL  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1001;

   localparam logic [3:0] IMM_I   = 4'b0000;
   localparam logic [3:0] IMM_S   = 4'b0001;
   localparam logic [3:0] IMM_B   = 4'b0010;
   localparam logic [3:0] IMM_U   = 4'b0011;
   localparam logic [3:0] IMM_J   = 4'b0100;
   localparam logic [3:0] IMM_LB  = 4'b0101;
   localparam logic [3:0] IMM_LH  = 4'b0110;
   localparam logic [3:0] IMM_LW  = 4'b0111;
   localparam logic [3:0] IMM_LBU = 4'b1000;
   localparam logic [3:0] IMM_LHU = 4'b1001;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        alt;
   logic        opcode_legal;
   logic        retire;
   logic [3:0]  next_state;
   logic        unused_instr_bits;

   assign opcode            = instr[6:0];
   assign funct3            = instr[14:12];
   assign alt               = instr[30];
   assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

   // Shared R/I-type ALU decode; use_alt selects SUB/SRA from instr[30].
   function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic use_alt);
      logic [3:0] op;
      op = ALU_ADD;
      case (f3)
         3'b000:  op = use_alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = use_alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   always_comb begin
      opcode_legal = 1'b0;
      case (opcode)
         OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH,
         OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: opcode_legal = 1'b1;
         default:                           opcode_legal = 1'b0;
      endcase
   end

   always_comb begin
      next_state = FETCH;
      case (State)
         FETCH:   next_state = DECODE;
         DECODE: begin
            case (opcode)
               OP_LOAD, OP_STORE: next_state = MEMADR;
               OP_R:              next_state = EXECR;
               OP_I:              next_state = EXECI;
               OP_BRANCH:         next_state = BRANCH;
               OP_JAL:            next_state = JAL;
               OP_JALR:           next_state = JALR;
               OP_LUI:            next_state = LUI;
               OP_AUIPC:          next_state = AUIPC;
               default:           next_state = FETCH;
            endcase
         end
         MEMADR:  next_state = (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
         MEMREAD: next_state = MEMWB;
         EXECR:   next_state = ALUWB;
         EXECI:   next_state = ALUWB;
         default: next_state = FETCH;
      endcase
   end

   // Every final state of an instruction retires it on the way back to FETCH.
   always_comb begin
      retire = 1'b0;
      case (State)
         MEMWB, MEMWRITE, ALUWB, BRANCH, JAL, JALR, LUI, AUIPC: retire = 1'b1;
         default:                                               retire = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         State        <= FETCH;
         InstrRetired <= 32'd0;
      end else begin
         State <= next_state;
         if (retire) begin
            InstrRetired <= InstrRetired + 32'd1;
         end
      end
   end

   always_comb begin
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      ImmIn      = 1'b0;
      RegSrc     = 1'b0;
      MemWrite   = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      MemSize    = 2'b00;
      ALUControl = ALU_ADD;
      ImmSrc     = IMM_I;
      Illegal    = 1'b0;
      case (State)
         FETCH: begin
            IRWrite   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            PCWrite   = 1'b1;
         end
         DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            ImmSrc  = IMM_B;
            Illegal = ~opcode_legal;
         end
         MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            ImmSrc  = (opcode == OP_STORE) ? IMM_S : IMM_I;
         end
         MEMREAD: begin
            AdrSrc  = 1'b1;
            MemSize = funct3[1:0];
         end
         MEMWB: begin
            ImmIn     = 1'b1;
            ResultSrc = 2'b01;
            RegWrite  = 1'b1;
            case (funct3)
               3'b000:  ImmSrc = IMM_LB;
               3'b001:  ImmSrc = IMM_LH;
               3'b100:  ImmSrc = IMM_LBU;
               3'b101:  ImmSrc = IMM_LHU;
               default: ImmSrc = IMM_LW;
            endcase
         end
         MEMWRITE: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
            MemSize  = funct3[1:0];
         end
         EXECR: begin
            ALUSrcA    = 2'b10;
            ALUControl = alu_decode(funct3, alt);
         end
         EXECI: begin
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b01;
            ALUControl = alu_decode(funct3, alt && (funct3 != 3'b000));
         end
         ALUWB: begin
            RegWrite = 1'b1;
         end
         // SLT/SLTU leave 1 in the ALU when "less than", so Zero means not-less.
         BRANCH: begin
            ALUSrcA = 2'b10;
            case (funct3)
               3'b000:  begin ALUControl = ALU_SUB;  PCWrite = Zero;  end
               3'b001:  begin ALUControl = ALU_SUB;  PCWrite = ~Zero; end
               3'b100:  begin ALUControl = ALU_SLT;  PCWrite = ~Zero; end
               3'b101:  begin ALUControl = ALU_SLT;  PCWrite = Zero;  end
               3'b110:  begin ALUControl = ALU_SLTU; PCWrite = ~Zero; end
               3'b111:  begin ALUControl = ALU_SLTU; PCWrite = Zero;  end
               default: begin ALUControl = ALU_ADD;  PCWrite = 1'b0;  end
            endcase
         end
         JAL, JALR: begin
            ALUSrcA   = (State == JAL) ? 2'b01 : 2'b10;
            ALUSrcB   = 2'b01;
            ImmSrc    = (State == JAL) ? IMM_J : IMM_I;
            ResultSrc = 2'b10;
            PCWrite   = 1'b1;
            RegWrite  = 1'b1;
            RegSrc    = 1'b1;
         end
         LUI: begin
            ALUSrcB   = 2'b01;
            ImmSrc    = IMM_U;
            ResultSrc = 2'b11;
            RegWrite  = 1'b1;
         end
         AUIPC: begin
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b01;
            ImmSrc    = IMM_U;
            ResultSrc = 2'b10;
            RegWrite  = 1'b1;
         end
         default: begin
            PCWrite = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: a per-instruction behavioural model predicts the
// state walk, control word and retire count each cycle, plus hand-computed spot checks.
module tb_multicycle_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr;
   logic        Zero;
   logic        PCWrite, AdrSrc, IRWrite, RegWrite, ImmIn, RegSrc, MemWrite;
   logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, MemSize;
   logic [3:0]  ALUControl, ImmSrc, State;
   logic        Illegal;
   logic [31:0] InstrRetired;

   always #5 clk = ~clk;

   multicycle_controller dut (
      .clk(clk), .reset(reset), .instr(instr), .Zero(Zero),
      .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .RegWrite(RegWrite),
      .ImmIn(ImmIn), .RegSrc(RegSrc), .MemWrite(MemWrite), .ResultSrc(ResultSrc),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .MemSize(MemSize), .ALUControl(ALUControl),
      .ImmSrc(ImmSrc), .State(State), .Illegal(Illegal), .InstrRetired(InstrRetired)
   );

   typedef struct packed {
      logic       PCWrite, AdrSrc, IRWrite, RegWrite, ImmIn, RegSrc, MemWrite;
      logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, MemSize;
      logic [3:0] ALUControl, ImmSrc;
      logic       Illegal;
   } ctl_t;

   typedef struct {
      logic [31:0] ins;
      logic        z;
   } vec_t;

   localparam logic [3:0] RALU  [8] = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
   localparam logic [3:0] LDIMM [8] = '{4'd5, 4'd6, 4'd7, 4'd7, 4'd8, 4'd9, 4'd7, 4'd7};

   int          total = 0;
   int          bad = 0;
   bit          checking = 1'b0;
   logic [3:0]  exp_state;
   logic [31:0] exp_retired;
   ctl_t        snap [16];
   int          path [$];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, wanted %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit isLegal(input logic [6:0] op);
      return op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                        7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
   endfunction

   // ALU op for R/I arithmetic: SUB and SRA sit one code above ADD and SRL.
   function automatic logic [3:0] aluOf(input logic [2:0] f3, input logic alt);
      logic [3:0] a;
      a = RALU[f3];
      if (alt && (f3 == 3'd0 || f3 == 3'd5)) a = a + 4'd1;
      return a;
   endfunction

   function automatic ctl_t expectedCtl(input logic [3:0] st, input logic [31:0] ins, input logic z);
      ctl_t       c;
      logic [2:0] f3;
      c  = '0;
      f3 = ins[14:12];
      case (st)
         4'd0:  begin c.IRWrite = 1; c.ALUSrcB = 2; c.ResultSrc = 2; c.PCWrite = 1; end
         4'd1:  begin c.ALUSrcA = 1; c.ALUSrcB = 1; c.ImmSrc = 2; c.Illegal = !isLegal(ins[6:0]); end
         4'd2:  begin c.ALUSrcA = 2; c.ALUSrcB = 1; c.ImmSrc = (ins[6:0] == 7'b0100011) ? 4'd1 : 4'd0; end
         4'd3:  begin c.AdrSrc = 1; c.MemSize = f3[1:0]; end
         4'd4:  begin c.ImmIn = 1; c.ResultSrc = 1; c.RegWrite = 1; c.ImmSrc = LDIMM[f3]; end
         4'd5:  begin c.AdrSrc = 1; c.MemWrite = 1; c.MemSize = f3[1:0]; end
         4'd6:  begin c.ALUSrcA = 2; c.ALUControl = aluOf(f3, ins[30]); end
         4'd7:  begin c.ALUSrcA = 2; c.ALUSrcB = 1; c.ALUControl = aluOf(f3, (f3 != 0) && ins[30]); end
         4'd8:  begin c.RegWrite = 1; end
         4'd9:  begin
            c.ALUSrcA    = 2;
            c.ALUControl = f3[2] ? (f3[1] ? 4'd6 : 4'd5) : (f3[1] ? 4'd0 : 4'd1);
            c.PCWrite    = (f3[2:1] == 2'b01) ? 1'b0 : (z ^ f3[0] ^ f3[2]);
         end
         4'd10: begin c.ALUSrcA = 1; c.ALUSrcB = 1; c.ImmSrc = 4; c.ResultSrc = 2;
                      c.PCWrite = 1; c.RegWrite = 1; c.RegSrc = 1; end
         4'd11: begin c.ALUSrcA = 2; c.ALUSrcB = 1; c.ImmSrc = 0; c.ResultSrc = 2;
                      c.PCWrite = 1; c.RegWrite = 1; c.RegSrc = 1; end
         4'd12: begin c.ALUSrcB = 1; c.ImmSrc = 3; c.ResultSrc = 3; c.RegWrite = 1; end
         4'd13: begin c.ALUSrcA = 1; c.ALUSrcB = 1; c.ImmSrc = 3; c.ResultSrc = 2; c.RegWrite = 1; end
         default: c = '0;
      endcase
      return c;
   endfunction

   task automatic pathFor(input logic [31:0] ins);
      case (ins[6:0])
         7'b0000011: path = '{0, 1, 2, 3, 4};
         7'b0100011: path = '{0, 1, 2, 5};
         7'b0110011: path = '{0, 1, 6, 8};
         7'b0010011: path = '{0, 1, 7, 8};
         7'b1100011: path = '{0, 1, 9};
         7'b1101111: path = '{0, 1, 10};
         7'b1100111: path = '{0, 1, 11};
         7'b0110111: path = '{0, 1, 12};
         7'b0010111: path = '{0, 1, 13};
         default:    path = '{0, 1};
      endcase
   endtask

   always @(negedge clk) begin : compare
      ctl_t e;
      ctl_t a;
      if (checking) begin
         e = expectedCtl(exp_state, instr, Zero);
         a = {PCWrite, AdrSrc, IRWrite, RegWrite, ImmIn, RegSrc, MemWrite, ResultSrc,
              ALUSrcA, ALUSrcB, MemSize, ALUControl, ImmSrc, Illegal};
         checkOutput("State", {28'd0, State}, {28'd0, exp_state});
         checkOutput("controls", {8'd0, a}, {8'd0, e});
         checkOutput("InstrRetired", InstrRetired, exp_retired);
         snap[State] = a;
      end
   end

   // Entered at posedge+1 with the DUT in FETCH; leaves it back in FETCH.
   task automatic applyStimulus(input logic [31:0] ins, input logic z);
      instr = ins;
      Zero  = z;
      pathFor(ins);
      foreach (path[i]) begin
         exp_state = 4'(path[i]);
         @(posedge clk);
         #1;
      end
      if (path.size() > 2) exp_retired = exp_retired + 32'd1;
      exp_state = 4'd0;
   endtask

   vec_t vecs [18] = '{
      '{32'h40208133, 1'b0}, '{32'h0020A1B3, 1'b0}, '{32'h0020B1B3, 1'b0},
      '{32'h0FF0F093, 1'b0}, '{32'h00208283, 1'b0}, '{32'h0080D283, 1'b0},
      '{32'h0080B283, 1'b0}, '{32'h0050A423, 1'b0}, '{32'h00508423, 1'b0},
      '{32'h00209463, 1'b0}, '{32'h0020C463, 1'b1}, '{32'h0020F463, 1'b0},
      '{32'h0020A463, 1'b1}, '{32'h0020D463, 1'b1}, '{32'h0020E463, 1'b0},
      '{32'h000080E7, 1'b0}, '{32'h123450B7, 1'b0}, '{32'h00001097, 1'b0}
   };

   initial begin
      reset       = 1'b1;
      instr       = 32'h0;
      Zero        = 1'b0;
      exp_state   = 4'd0;
      exp_retired = 32'd0;
      checking    = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("reset_state", {28'd0, State}, 32'd0);
      checkOutput("reset_retired", InstrRetired, 32'd0);
      checkOutput("reset_illegal", {31'd0, Illegal}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      applyStimulus(32'h002081B3, 1'b0);
      checkOutput("add_execr_alu", {28'd0, snap[6].ALUControl}, 32'd0);
      checkOutput("add_aluwb_regwrite", {31'd0, snap[8].RegWrite}, 32'd1);
      checkOutput("add_retired", InstrRetired, 32'd1);

      applyStimulus(32'h0080A283, 1'b0);
      checkOutput("lw_memread_adrsrc", {31'd0, snap[3].AdrSrc}, 32'd1);
      checkOutput("lw_memwb_immin", {31'd0, snap[4].ImmIn}, 32'd1);
      checkOutput("lw_memwb_resultsrc", {30'd0, snap[4].ResultSrc}, 32'd1);
      checkOutput("lw_memwb_immsrc", {28'd0, snap[4].ImmSrc}, 32'd7);

      applyStimulus(32'h00208463, 1'b1);
      checkOutput("beq_z1_pcwrite", {31'd0, snap[9].PCWrite}, 32'd1);
      checkOutput("beq_z1_alu", {28'd0, snap[9].ALUControl}, 32'd1);
      applyStimulus(32'h00208463, 1'b0);
      checkOutput("beq_z0_pcwrite", {31'd0, snap[9].PCWrite}, 32'd0);
      checkOutput("beq_z0_alu", {28'd0, snap[9].ALUControl}, 32'd1);

      applyStimulus(32'h010000EF, 1'b0);
      checkOutput("jal_regwrite", {31'd0, snap[10].RegWrite}, 32'd1);
      checkOutput("jal_regsrc", {31'd0, snap[10].RegSrc}, 32'd1);
      checkOutput("jal_pcwrite", {31'd0, snap[10].PCWrite}, 32'd1);
      checkOutput("jal_immsrc", {28'd0, snap[10].ImmSrc}, 32'd4);
      checkOutput("jal_retired", InstrRetired, 32'd5);

      applyStimulus(32'hFFFFFFFF, 1'b0);
      checkOutput("illegal_pulse", {31'd0, snap[1].Illegal}, 32'd1);
      checkOutput("illegal_back_to_fetch", {28'd0, State}, 32'd0);
      checkOutput("illegal_retired", InstrRetired, 32'd5);

      applyStimulus(32'h4020D1B3, 1'b0);
      checkOutput("sra_alu", {28'd0, snap[6].ALUControl}, 32'd9);
      applyStimulus(32'hC0000093, 1'b0);
      checkOutput("addi_bit30_alu", {28'd0, snap[7].ALUControl}, 32'd0);
      applyStimulus(32'h4030D093, 1'b0);
      checkOutput("srai_alu", {28'd0, snap[7].ALUControl}, 32'd9);

      foreach (vecs[i]) applyStimulus(vecs[i].ins, vecs[i].z);
      checkOutput("retired_after_table", InstrRetired, 32'd26);

      // Abandon an add in EXECR with an asynchronous reset between clock edges.
      instr     = 32'h002081B3;
      Zero      = 1'b0;
      exp_state = 4'd0;
      @(posedge clk);
      #1;
      exp_state = 4'd1;
      @(posedge clk);
      #1;
      exp_state = 4'd6;
      checkOutput("pre_reset_state", {28'd0, State}, 32'd6);
      #2;
      reset       = 1'b1;
      exp_state   = 4'd0;
      exp_retired = 32'd0;
      #1;
      checkOutput("async_reset_state", {28'd0, State}, 32'd0);
      checkOutput("async_reset_retired", InstrRetired, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      applyStimulus(32'h002081B3, 1'b0);
      checkOutput("post_reset_retired", InstrRetired, 32'd1);

      checking = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
